// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Brief    : Shared dimensions, lane widths and FSM encoding for the
//             sprite motion scheduler.
//  Revision : 1.0
// ============================================================================
package sprite_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_W    = 36;
  localparam int SPRITE_H    = 54;
  localparam int XMAX        = SCREEN_W - SPRITE_W;
  localparam int YMAX        = SCREEN_H - SPRITE_H;
  localparam int SPRITE_SIZE = SPRITE_W * SPRITE_H;

  localparam int LANE_W = 10;
  localparam int POS_W  = 11;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_UPD_X    = 3'd1;
  localparam state_t ST_UPD_Y    = 3'd2;
  localparam state_t ST_UPD_ANIM = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/bounce_step.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_step
//  Brief    : One-pixel move along a single axis with clamp-and-reflect at
//             0 and max. Purely combinational.
//  Revision : 1.0
// ============================================================================
module bounce_step
  import sprite_pkg::*;
(
  input  logic [LANE_W-1:0] pos,
  input  logic              dir,
  input  logic [LANE_W-1:0] max,
  output logic [LANE_W-1:0] new_pos,
  output logic              new_dir
);

  logic signed [POS_W-1:0] w_base;
  logic signed [POS_W-1:0] w_sum;
  logic signed [POS_W-1:0] w_max;

  assign w_base = $signed({1'b0, pos});
  assign w_max  = $signed({1'b0, max});
  assign w_sum  = dir ? (w_base - 11'sd1) : (w_base + 11'sd1);

  // Exact landing on an edge keeps the direction; reflection happens when
  // the next step would overshoot.
  always_comb begin
    new_pos = w_sum[LANE_W-1:0];
    new_dir = dir;
    if (w_sum > w_max) begin
      new_pos = max;
      new_dir = ~dir;
    end else if (w_sum < 11'sd0) begin
      new_pos = '0;
      new_dir = ~dir;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_motion_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_motion_scheduler
//  Brief    : Per-frame sequencer that steps X, Y and animation state of each
//             sprite in turn through one shared bounce datapath.
//  Revision : 1.0
// ============================================================================
module sprite_motion_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = SPRITE_W,
  parameter int SPRITE_HEIGHT = SPRITE_H,
  parameter int SCREEN_WIDTH  = SCREEN_W,
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter int ANIM_FRAMES   = 2,
  parameter int ANIM_PERIOD   = 32,
  parameter int ADR_W         = 12
) (
  input  logic                          clk25,
  input  logic                          rst,
  input  logic                          frame,
  input  logic                          freeze,
  output logic [LANE_W*NUM_SPRITES-1:0] x_pos,
  output logic [LANE_W*NUM_SPRITES-1:0] y_pos,
  output logic [ADR_W*NUM_SPRITES-1:0]  frame_base,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int XMAX_P = SCREEN_WIDTH - SPRITE_WIDTH;
  localparam int YMAX_P = SCREEN_HEIGHT - SPRITE_HEIGHT;
  localparam int SIZE_P = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int XSTEP  = XMAX_P / NUM_SPRITES;
  localparam int YINIT  = YMAX_P / 2;
  localparam int IDX_W  = $clog2(NUM_SPRITES);
  localparam int CNT_W  = $clog2(ANIM_PERIOD);
  localparam int AIDX_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_overrun;
  logic               w_start;
  logic               w_last;

  logic [LANE_W*NUM_SPRITES-1:0] w_x_all;
  logic [LANE_W*NUM_SPRITES-1:0] w_y_all;
  logic [NUM_SPRITES-1:0]        w_dx_all;
  logic [NUM_SPRITES-1:0]        w_dy_all;
  logic [CNT_W*NUM_SPRITES-1:0]  w_cnt_all;
  logic [AIDX_W*NUM_SPRITES-1:0] w_aidx_all;

  logic                 w_is_y;
  logic [LANE_W-1:0]    w_step_pos;
  logic                 w_step_dir;
  logic [LANE_W-1:0]    w_step_max;
  logic [LANE_W-1:0]    w_new_pos;
  logic                 w_new_dir;

  logic [CNT_W-1:0]     w_cnt_cur;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [AIDX_W-1:0]    w_aidx_cur;
  logic [AIDX_W-1:0]    w_aidx_next;
  logic [ADR_W-1:0]     w_fb_next;

  assign w_start = frame && !freeze;
  assign w_last  = (r_idx == IDX_W'(NUM_SPRITES - 1));

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_next = ST_UPD_X;
      ST_UPD_X:    w_next = ST_UPD_Y;
      ST_UPD_Y:    w_next = ST_UPD_ANIM;
      ST_UPD_ANIM: w_next = w_last ? ST_DONE : ST_UPD_X;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_start)
        r_idx <= '0;
      else if (r_state == ST_UPD_ANIM && !w_last)
        r_idx <= r_idx + IDX_W'(1);
      if (r_state != ST_IDLE && w_start)
        r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;

  // One bounce datapath serves both axes; the state picks the operands.
  assign w_is_y     = (r_state == ST_UPD_Y);
  assign w_step_pos = w_is_y ? w_y_all[r_idx*LANE_W +: LANE_W] : w_x_all[r_idx*LANE_W +: LANE_W];
  assign w_step_dir = w_is_y ? w_dy_all[r_idx] : w_dx_all[r_idx];
  assign w_step_max = w_is_y ? LANE_W'(YMAX_P) : LANE_W'(XMAX_P);

  bounce_step u_bounce_step (
    .pos     (w_step_pos),
    .dir     (w_step_dir),
    .max     (w_step_max),
    .new_pos (w_new_pos),
    .new_dir (w_new_dir)
  );

  assign w_cnt_cur   = w_cnt_all[r_idx*CNT_W +: CNT_W];
  assign w_cnt_next  = w_cnt_cur + CNT_W'(1);
  assign w_aidx_cur  = w_aidx_all[r_idx*AIDX_W +: AIDX_W];

  always_comb begin
    w_aidx_next = w_aidx_cur;
    if (w_cnt_next == '0) begin
      if (w_aidx_cur == AIDX_W'(ANIM_FRAMES - 1)) w_aidx_next = '0;
      else                                        w_aidx_next = w_aidx_cur + AIDX_W'(1);
    end
  end

  assign w_fb_next = ADR_W'(int'(w_aidx_next) * SIZE_P);

  genvar i;
  generate
    for (i = 0; i < NUM_SPRITES; i++) begin : g_sprite
      localparam logic [LANE_W-1:0] X_INIT   = LANE_W'(i * XSTEP);
      localparam logic [LANE_W-1:0] Y_INIT   = LANE_W'(YINIT);
      localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((i * 8) % ANIM_PERIOD);
      localparam logic              DX_INIT  = 1'((i % 2));

      logic              r_dx, r_dy, w_sel;
      logic [LANE_W-1:0] r_x, r_y;
      logic [CNT_W-1:0]  r_cnt;
      logic [AIDX_W-1:0] r_aidx;
      logic [ADR_W-1:0]  r_fb;

      assign w_sel = (r_idx == IDX_W'(i));

      always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
          r_x    <= X_INIT;
          r_y    <= Y_INIT;
          r_dx   <= DX_INIT;
          r_dy   <= 1'b0;
          r_cnt  <= CNT_INIT;
          r_aidx <= '0;
          r_fb   <= '0;
        end else if (w_sel) begin
          case (r_state)
            ST_UPD_X: begin
              r_x  <= w_new_pos;
              r_dx <= w_new_dir;
            end
            ST_UPD_Y: begin
              r_y  <= w_new_pos;
              r_dy <= w_new_dir;
            end
            ST_UPD_ANIM: begin
              r_cnt  <= w_cnt_next;
              r_aidx <= w_aidx_next;
              r_fb   <= w_fb_next;
            end
            default: ;
          endcase
        end
      end

      assign w_x_all[i*LANE_W +: LANE_W]   = r_x;
      assign w_y_all[i*LANE_W +: LANE_W]   = r_y;
      assign w_dx_all[i]                   = r_dx;
      assign w_dy_all[i]                   = r_dy;
      assign w_cnt_all[i*CNT_W +: CNT_W]   = r_cnt;
      assign w_aidx_all[i*AIDX_W +: AIDX_W] = r_aidx;
      assign frame_base[i*ADR_W +: ADR_W]  = r_fb;
    end
  endgenerate

  assign x_pos = w_x_all;
  assign y_pos = w_y_all;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_motion_scheduler
//  Brief    : Randomized-gap frame stimulus against a per-sprite arithmetic
//             model, plus directed edge, animation, overrun, freeze and reset cases.
//  Revision : 1.0
// ============================================================================
module tb_sprite_motion_scheduler;

  localparam int N   = 4;
  localparam int SW  = 36;
  localparam int SH  = 54;
  localparam int SCW = 640;
  localparam int SCH = 480;
  localparam int AF  = 2;
  localparam int AP  = 32;
  localparam int AW  = 12;
  localparam int XM  = SCW - SW;
  localparam int YM  = SCH - SH;
  localparam int SZ  = SW * SH;

  logic            clk25 = 1'b0;
  logic            rst, frame, freeze;
  logic [10*N-1:0] x_pos, y_pos;
  logic [AW*N-1:0] frame_base;
  logic            busy, done, overrun;

  int errors = 0;
  int checks = 0;
  int nf     = 0;

  int mx[N], my[N], mdx[N], mdy[N], mcnt[N], mai[N];

  typedef struct { int nf; int kind; int lane; int val; } pt_t;

  always #20 clk25 = ~clk25;

  sprite_motion_scheduler #(
    .NUM_SPRITES(N), .SPRITE_WIDTH(SW), .SPRITE_HEIGHT(SH),
    .SCREEN_WIDTH(SCW), .SCREEN_HEIGHT(SCH),
    .ANIM_FRAMES(AF), .ANIM_PERIOD(AP), .ADR_W(AW)
  ) dut (
    .clk25(clk25), .rst(rst), .frame(frame), .freeze(freeze),
    .x_pos(x_pos), .y_pos(y_pos), .frame_base(frame_base),
    .busy(busy), .done(done), .overrun(overrun)
  );

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]   = i * (XM / N);
      my[i]   = YM / 2;
      mdx[i]  = (i % 2 == 0) ? 1 : -1;
      mdy[i]  = 1;
      mcnt[i] = (i * 8) % AP;
      mai[i]  = 0;
    end
  endfunction

  function automatic void model_frame();
    int n;
    for (int i = 0; i < N; i++) begin
      n = mx[i] + mdx[i];
      if (n > XM)      begin mx[i] = XM; mdx[i] = -mdx[i]; end
      else if (n < 0)  begin mx[i] = 0;  mdx[i] = -mdx[i]; end
      else             mx[i] = n;
      n = my[i] + mdy[i];
      if (n > YM)      begin my[i] = YM; mdy[i] = -mdy[i]; end
      else if (n < 0)  begin my[i] = 0;  mdy[i] = -mdy[i]; end
      else             my[i] = n;
      mcnt[i] = (mcnt[i] + 1) % AP;
      if (mcnt[i] == 0) mai[i] = (mai[i] + 1) % AF;
    end
  endfunction

  function automatic logic [10*N-1:0] ref_x();
    logic [10*N-1:0] v;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(mx[i]);
    return v;
  endfunction

  function automatic logic [10*N-1:0] ref_y();
    logic [10*N-1:0] v;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(my[i]);
    return v;
  endfunction

  function automatic logic [AW*N-1:0] ref_fb();
    logic [AW*N-1:0] v;
    for (int i = 0; i < N; i++) v[AW*i +: AW] = AW'(mai[i] * SZ);
    return v;
  endfunction

  task automatic do_frame(output int bc, output int dc);
    bc = 0;
    dc = 0;
    @(negedge clk25) frame = 1'b1;
    @(negedge clk25) frame = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy) bc++;
      if (done) dc++;
      if (!busy && bc > 0) break;
      @(negedge clk25);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk25);
    rst = 1'b0;
    model_reset();
    nf = 0;
    @(negedge clk25);
    checks++;
    if (x_pos !== ref_x() || y_pos !== ref_y() || frame_base !== ref_fb()) begin
      errors++;
      $display("FAIL reset_pos: got x=%h y=%h fb=%h want x=%h y=%h fb=%h",
               x_pos, y_pos, frame_base, ref_x(), ref_y(), ref_fb());
    end
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/overrun=%b want 000", {busy, done, overrun});
    end
  endtask

  task automatic test_first_frame();
    int bc, dc;
    do_frame(bc, dc);
    model_frame(); nf++;
    checks++;
    if (bc !== 13 || dc !== 1) begin
      errors++;
      $display("FAIL first_timing: got busy=%0d done=%0d want busy=13 done=1", bc, dc);
    end
    checks++;
    if (x_pos[9:0] !== 10'd1 || y_pos[9:0] !== 10'd214) begin
      errors++;
      $display("FAIL sprite0_step: got (%0d,%0d) want (1,214)", x_pos[9:0], y_pos[9:0]);
    end
    checks++;
    if (x_pos[19:10] !== 10'd150 || y_pos[19:10] !== 10'd214) begin
      errors++;
      $display("FAIL sprite1_step: got (%0d,%0d) want (150,214)", x_pos[19:10], y_pos[19:10]);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL first_overrun: got %b want 0", overrun);
    end
  endtask

  task automatic test_motion();
    int bc, dc, got, bz;
    pt_t pts[18];
    pts = '{'{23,2,1,0},    '{24,2,1,1944}, '{31,2,0,0},    '{32,2,0,1944},
            '{56,2,1,0},    '{64,2,0,0},
            '{151,0,1,0},   '{152,0,1,0},   '{153,0,1,1},
            '{213,1,0,426}, '{214,1,0,426}, '{215,1,0,425},
            '{604,0,0,604}, '{605,0,0,604}, '{606,0,0,603},
            '{640,1,0,0},   '{641,1,0,0},   '{642,1,0,1}};
    while (nf < 650) begin
      if ($urandom_range(0, 7) == 0) begin
        bz = 0;
        @(negedge clk25) begin frame = 1'b1; freeze = 1'b1; end
        @(negedge clk25) begin frame = 1'b0; freeze = 1'b0; end
        for (int k = 0; k < 4; k++) begin
          if (busy) bz++;
          @(negedge clk25);
        end
        checks++;
        if (bz !== 0 || x_pos !== ref_x() || y_pos !== ref_y()) begin
          errors++;
          $display("FAIL freeze_in_run: got busy_cycles=%0d x=%h want 0 x=%h", bz, x_pos, ref_x());
        end
      end
      do_frame(bc, dc);
      model_frame(); nf++;
      checks++;
      if (bc !== 13 || dc !== 1) begin
        errors++;
        $display("FAIL run_timing f%0d: got busy=%0d done=%0d want 13/1", nf, bc, dc);
      end
      checks++;
      if (x_pos !== ref_x() || y_pos !== ref_y() || frame_base !== ref_fb()) begin
        errors++;
        $display("FAIL run_state f%0d: got x=%h y=%h fb=%h want x=%h y=%h fb=%h",
                 nf, x_pos, y_pos, frame_base, ref_x(), ref_y(), ref_fb());
      end
      foreach (pts[p]) begin
        if (pts[p].nf == nf) begin
          case (pts[p].kind)
            0:       got = int'(x_pos[10*pts[p].lane +: 10]);
            1:       got = int'(y_pos[10*pts[p].lane +: 10]);
            default: got = int'(frame_base[AW*pts[p].lane +: AW]);
          endcase
          checks++;
          if (got !== pts[p].val) begin
            errors++;
            $display("FAIL edge_point f%0d kind%0d lane%0d: got %0d want %0d",
                     nf, pts[p].kind, pts[p].lane, got, pts[p].val);
          end
        end
      end
      repeat ($urandom_range(0, 4)) @(negedge clk25);
    end
  endtask

  task automatic test_overrun();
    int bc, dc, bz;
    bc = 0; dc = 0; bz = 0;
    @(negedge clk25) frame = 1'b1;
    @(negedge clk25) frame = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (busy) bc++;
      if (done) dc++;
      if (!busy && bc > 0) break;
      frame = (bc == 5);
      @(negedge clk25);
    end
    frame = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy) bz++;
      @(negedge clk25);
    end
    model_frame(); nf++;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    checks++;
    if (bc !== 13 || dc !== 1 || bz !== 0) begin
      errors++;
      $display("FAIL overrun_timing: got busy=%0d done=%0d extra=%0d want 13/1/0", bc, dc, bz);
    end
    checks++;
    if (x_pos !== ref_x() || y_pos !== ref_y() || frame_base !== ref_fb()) begin
      errors++;
      $display("FAIL overrun_state: got x=%h y=%h want x=%h y=%h", x_pos, y_pos, ref_x(), ref_y());
    end
    do_frame(bc, dc);
    model_frame(); nf++;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_freeze();
    int bz;
    bz = 0;
    @(negedge clk25) begin frame = 1'b1; freeze = 1'b1; end
    @(negedge clk25) begin frame = 1'b0; freeze = 1'b0; end
    for (int k = 0; k < 20; k++) begin
      if (busy || done) bz++;
      @(negedge clk25);
    end
    checks++;
    if (bz !== 0) begin
      errors++;
      $display("FAIL freeze_busy: got active_cycles=%0d want 0", bz);
    end
    checks++;
    if (x_pos !== ref_x() || y_pos !== ref_y() || frame_base !== ref_fb()) begin
      errors++;
      $display("FAIL freeze_state: got x=%h y=%h want x=%h y=%h", x_pos, y_pos, ref_x(), ref_y());
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, cnt;
    @(negedge clk25) frame = 1'b1;
    @(negedge clk25) frame = 1'b0;
    cnt = 1;
    while (cnt < 6) begin
      @(negedge clk25);
      cnt++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midseq_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    model_reset();
    nf = 0;
    @(posedge clk25);
    #1;
    checks++;
    if (x_pos !== ref_x() || y_pos !== ref_y() || frame_base !== ref_fb()) begin
      errors++;
      $display("FAIL midseq_reset_state: got x=%h y=%h fb=%h want x=%h y=%h fb=%h",
               x_pos, y_pos, frame_base, ref_x(), ref_y(), ref_fb());
    end
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL midseq_reset_flags: got %b want 000", {busy, done, overrun});
    end
    @(negedge clk25) rst = 1'b0;
    do_frame(bc, dc);
    model_frame(); nf++;
    checks++;
    if (bc !== 13 || x_pos !== ref_x() || y_pos !== ref_y()) begin
      errors++;
      $display("FAIL after_reset_frame: got busy=%0d x=%h want 13 x=%h", bc, x_pos, ref_x());
    end
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_motion();
    test_overrun();
    test_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
